// File: rtl/prog_mod_counter.sv
// prog_mod_counter: programmable-modulus up/down counter with synchronous
// clear, parallel load, enable and one-shot/periodic operation. The modulus
// is a runtime register (0 encodes 2^N), so a single instance can serve as a
// baud/tick generator, timer or cascaded prescaler.
// Optional feature: define PROG_MOD_COUNTER_WRAPCNT_EN to add the saturating
// wrap_cnt output that counts wrap events.
module prog_mod_counter #(
    parameter int N     = 8,
    parameter int M_RST = 10,
    parameter int WC_W  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         m_wr,
    input  logic [N-1:0] m_in,
    input  logic         up,
    input  logic         oneshot,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap_tick,
    output logic         done
`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
    ,
    output logic [WC_W-1:0] wrap_cnt
`endif
);

    // M_RST == 2^N truncates to 0, which is exactly the full-range encoding.
    localparam logic [N-1:0] M_RST_ENC = N'(M_RST);
    localparam logic [N-1:0] ONE       = N'(1);

    // Elaboration-time parameter sanity checks.
    if (N < 2 || N > 32) begin : g_bad_n
        $error("prog_mod_counter: N must be in 2..32");
    end
    if (M_RST < 1 || longint'(M_RST) > (longint'(1) << N)) begin : g_bad_mrst
        $error("prog_mod_counter: M_RST must be in 1..2^N");
    end
    if (WC_W < 1) begin : g_bad_wcw
        $error("prog_mod_counter: WC_W must be at least 1");
    end

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] m_q, m_d;
    logic         done_q, done_d;
    logic [N-1:0] top;
    logic         at_term;
    logic         step_en;

    // Terminal value; m_q == 0 wraps to all-ones, giving the full 2^N range.
    assign top     = m_q - ONE;
    // Up uses >= so a shrunken modulus or an oversized load recovers at once.
    assign at_term = up ? (count_q >= top) : (count_q == '0);
    assign step_en = en & ~done_q;

    assign q         = count_q;
    assign done      = done_q;
    assign max_tick  = (count_q == top);
    assign min_tick  = (count_q == '0);
    // Held low while in reset so nothing downstream sees a spurious wrap.
    assign wrap_tick = ~reset & step_en & at_term;

    // Next-state decode: clear beats load beats a count step beats hold.
    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        m_d     = m_wr ? m_in : m_q;
        if (clr) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (step_en) begin
            if (up) begin
                count_d = at_term ? '0 : count_q + ONE;
            end else begin
                count_d = (count_q == '0 || count_q > top) ? top : count_q - ONE;
            end
            if (oneshot && at_term) begin
                done_d = 1'b1;
            end
        end
    end

    // State registers; reset restores count, modulus and the done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            m_q     <= M_RST_ENC;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            m_q     <= m_d;
            done_q  <= done_d;
        end
    end

`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

    logic [WC_W-1:0] wcnt_q, wcnt_d;

    // Saturating wrap counter; clr wins over a coincident wrap, load leaves it.
    always_comb begin
        wcnt_d = wcnt_q;
        if (clr) begin
            wcnt_d = '0;
        end else if (wrap_tick && (wcnt_q != '1)) begin
            wcnt_d = wcnt_q + WC_ONE;
        end
    end

    // Wrap counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wrap_cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed testbench for prog_mod_counter (N=8, M_RST=10, WC_W=2).
module tb_prog_mod_counter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, clr, load, m_wr, up, oneshot;
    logic [N-1:0] load_val, m_in;
    logic [N-1:0] q;
    logic         max_tick, min_tick, wrap_tick, done;
`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
    logic [1:0]   wrap_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    prog_mod_counter #(
        .N    (N),
        .M_RST(10),
        .WC_W (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .m_wr     (m_wr),
        .m_in     (m_in),
        .up       (up),
        .oneshot  (oneshot),
        .q        (q),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .wrap_tick(wrap_tick),
        .done     (done)
`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
        ,
        .wrap_cnt (wrap_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up = 1'b0; clr = 1'b0; load = 1'b0;
        m_wr = 1'b0; oneshot = 1'b0; load_val = '0; m_in = '0;
        tick();
        tick();
        vec_cnt++;
        if ({q, done, min_tick, max_tick, wrap_tick} !== {8'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_state: got q=%0d done=%b min=%b max=%b wrap=%b want q=0 done=0 min=1 max=0 wrap=0",
                     q, done, min_tick, max_tick, wrap_tick);
        end
        reset = 1'b0;
        up    = 1'b1;
        #1;
        $display("reset: q=%0d done=%b", q, done);
    endtask

    task automatic test_periodic_up();
        logic [N-1:0] exp_q;
        logic         exp_t;
        for (int i = 0; i < 12; i++) begin
            exp_q = N'(i % 10);
            exp_t = (exp_q == 8'd9);
            vec_cnt++;
            if ({q, max_tick, wrap_tick, done} !== {exp_q, exp_t, exp_t, 1'b0}) begin
                err_cnt++;
                $display("FAIL periodic_up[%0d]: got q=%0d max=%b wrap=%b done=%b want q=%0d max=%b wrap=%b done=0",
                         i, q, max_tick, wrap_tick, done, exp_q, exp_t, exp_t);
            end
            $display("periodic_up[%0d]: q=%0d wrap=%b", i, q, wrap_tick);
            tick();
        end
    endtask

    task automatic test_mod_write();
        logic [N-1:0] seq [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        for (int i = 0; i < 5; i++) tick();
        vec_cnt++;
        if (q !== 8'd7) begin
            err_cnt++;
            $display("FAIL mod_write_pre: got q=%0d want 7", q);
        end
        m_wr = 1'b1; m_in = 8'd4;
        tick();
        m_wr = 1'b0;
        #1;
        // The step coincident with the write used the old top, so 7 -> 8.
        vec_cnt++;
        if ({q, wrap_tick, max_tick} !== {8'd8, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL mod_write_old_top: got q=%0d wrap=%b max=%b want q=8 wrap=1 max=0",
                     q, wrap_tick, max_tick);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vec_cnt++;
            if ({q, wrap_tick} !== {seq[i], seq[i] == 8'd3}) begin
                err_cnt++;
                $display("FAIL mod_write_seq[%0d]: got q=%0d wrap=%b want q=%0d wrap=%b",
                         i, q, wrap_tick, seq[i], seq[i] == 8'd3);
            end
            $display("mod_write_seq[%0d]: q=%0d wrap=%b", i, q, wrap_tick);
        end
    endtask

    task automatic test_down();
        logic [N-1:0] seq [6] = '{8'd2, 8'd1, 8'd0, 8'd4, 8'd3, 8'd2};
        en = 1'b0; m_wr = 1'b1; m_in = 8'd5; load = 1'b1; load_val = 8'd2;
        tick();
        m_wr = 1'b0; load = 1'b0; up = 1'b0; en = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            vec_cnt++;
            if ({q, wrap_tick, min_tick} !== {seq[i], seq[i] == 8'd0, seq[i] == 8'd0}) begin
                err_cnt++;
                $display("FAIL down_seq[%0d]: got q=%0d wrap=%b min=%b want q=%0d wrap=%b min=%b",
                         i, q, wrap_tick, min_tick, seq[i], seq[i] == 8'd0, seq[i] == 8'd0);
            end
            $display("down_seq[%0d]: q=%0d wrap=%b", i, q, wrap_tick);
        end
        load = 1'b1; load_val = 8'd200;
        tick();
        load = 1'b0;
        #1;
        vec_cnt++;
        if ({q, wrap_tick} !== {8'd200, 1'b0}) begin
            err_cnt++;
            $display("FAIL down_load200: got q=%0d wrap=%b want q=200 wrap=0", q, wrap_tick);
        end
        tick();
        vec_cnt++;
        if (q !== 8'd4) begin
            err_cnt++;
            $display("FAIL down_recover: got q=%0d want 4", q);
        end
        load = 1'b1; load_val = 8'd200;
        tick();
        load = 1'b0; up = 1'b1;
        #1;
        vec_cnt++;
        if (wrap_tick !== 1'b1) begin
            err_cnt++;
            $display("FAIL up_over_top_wrap: got wrap=%b want 1", wrap_tick);
        end
        tick();
        vec_cnt++;
        if (q !== 8'd0) begin
            err_cnt++;
            $display("FAIL up_recover: got q=%0d want 0", q);
        end
        $display("down: recover checks q=%0d", q);
    endtask

    task automatic test_oneshot();
        logic [N-1:0] eq [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0};
        logic         ed [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic         ew [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        en = 1'b0; m_wr = 1'b1; m_in = 8'd3; clr = 1'b1;
        tick();
        m_wr = 1'b0; clr = 1'b0; oneshot = 1'b1; en = 1'b1; up = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            vec_cnt++;
            if ({q, done, wrap_tick} !== {eq[i], ed[i], ew[i]}) begin
                err_cnt++;
                $display("FAIL oneshot[%0d]: got q=%0d done=%b wrap=%b want q=%0d done=%b wrap=%b",
                         i, q, done, wrap_tick, eq[i], ed[i], ew[i]);
            end
            $display("oneshot[%0d]: q=%0d done=%b wrap=%b", i, q, done, wrap_tick);
        end
        // Down direction makes q=0 terminal; done must still mask wrap_tick.
        up = 1'b0;
        #1;
        vec_cnt++;
        if ({q, done, wrap_tick} !== {8'd0, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL oneshot_suppress: got q=%0d done=%b wrap=%b want q=0 done=1 wrap=0",
                     q, done, wrap_tick);
        end
        up = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        vec_cnt++;
        if ({q, done} !== {8'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL oneshot_clr: got q=%0d done=%b want q=0 done=0", q, done);
        end
        tick();
        vec_cnt++;
        if (q !== 8'd1) begin
            err_cnt++;
            $display("FAIL oneshot_resume: got q=%0d want 1", q);
        end
        tick();
        tick();
        vec_cnt++;
        if ({q, done} !== {8'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL oneshot_second_done: got q=%0d done=%b want q=0 done=1", q, done);
        end
        load = 1'b1; load_val = 8'd1;
        tick();
        load = 1'b0;
        #1;
        vec_cnt++;
        if ({q, done} !== {8'd1, 1'b0}) begin
            err_cnt++;
            $display("FAIL oneshot_load_restart: got q=%0d done=%b want q=1 done=0", q, done);
        end
        tick();
        vec_cnt++;
        if (q !== 8'd2) begin
            err_cnt++;
            $display("FAIL oneshot_load_count: got q=%0d want 2", q);
        end
        oneshot = 1'b0;
        $display("oneshot: restart checks q=%0d done=%b", q, done);
    endtask

    task automatic test_priority();
        logic [N-1:0] exp_q;
        clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'd5;
        tick();
        clr = 1'b0;
        #1;
        vec_cnt++;
        if (q !== 8'd0) begin
            err_cnt++;
            $display("FAIL prio_clr_load_en: got q=%0d want 0", q);
        end
        load_val = 8'd7;
        tick();
        load = 1'b0;
        #1;
        vec_cnt++;
        if (q !== 8'd7) begin
            err_cnt++;
            $display("FAIL prio_load_over_en: got q=%0d want 7", q);
        end
        en = 1'b0; m_wr = 1'b1; m_in = 8'd0; load = 1'b1; load_val = 8'd250;
        tick();
        m_wr = 1'b0; load = 1'b0; en = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_q = N'((250 + i) % 256);
            vec_cnt++;
            if ({q, max_tick, wrap_tick} !== {exp_q, exp_q == 8'd255, exp_q == 8'd255}) begin
                err_cnt++;
                $display("FAIL full_range[%0d]: got q=%0d max=%b wrap=%b want q=%0d max=%b wrap=%b",
                         i, q, max_tick, wrap_tick, exp_q, exp_q == 8'd255, exp_q == 8'd255);
            end
            $display("full_range[%0d]: q=%0d wrap=%b", i, q, wrap_tick);
            tick();
        end
    endtask

    task automatic test_m1();
        en = 1'b0; m_wr = 1'b1; m_in = 8'd1; clr = 1'b1;
        tick();
        m_wr = 1'b0; clr = 1'b0; en = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if ({q, max_tick, min_tick, wrap_tick} !== {8'd0, 1'b1, 1'b1, 1'b1}) begin
                err_cnt++;
                $display("FAIL m1[%0d]: got q=%0d max=%b min=%b wrap=%b want q=0 max=1 min=1 wrap=1",
                         i, q, max_tick, min_tick, wrap_tick);
            end
            $display("m1[%0d]: q=%0d wrap=%b", i, q, wrap_tick);
            tick();
        end
    endtask

    task automatic test_reset_midcount();
        en = 1'b0; m_wr = 1'b1; m_in = 8'd5; load = 1'b1; load_val = 8'd1;
        tick();
        m_wr = 1'b0; load = 1'b0; up = 1'b0; oneshot = 1'b1; en = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if ({q, done} !== {8'd4, 1'b1}) begin
            err_cnt++;
            $display("FAIL midreset_pre: got q=%0d done=%b want q=4 done=1", q, done);
        end
        #2;
        reset = 1'b1;
        #1;
        // Asynchronous: takes effect without a clock edge; top returns to 9.
        vec_cnt++;
        if ({q, done, max_tick, min_tick, wrap_tick} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL midreset: got q=%0d done=%b max=%b min=%b wrap=%b want q=0 done=0 max=0 min=1 wrap=0",
                     q, done, max_tick, min_tick, wrap_tick);
        end
        $display("midreset: q=%0d done=%b", q, done);
        reset = 1'b0; oneshot = 1'b0; up = 1'b1; en = 1'b0;
        tick();
    endtask

`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
    task automatic test_wrapcnt();
        logic [1:0] exp_w [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        vec_cnt++;
        if (wrap_cnt !== 2'd0) begin
            err_cnt++;
            $display("FAIL wrapcnt_reset: got %0d want 0", wrap_cnt);
        end
        m_wr = 1'b1; m_in = 8'd2; clr = 1'b1;
        tick();
        m_wr = 1'b0; clr = 1'b0; en = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            vec_cnt++;
            if (wrap_cnt !== exp_w[i]) begin
                err_cnt++;
                $display("FAIL wrapcnt[%0d]: got %0d want %0d", i, wrap_cnt, exp_w[i]);
            end
            $display("wrapcnt[%0d]: wrap_cnt=%0d", i, wrap_cnt);
        end
        load = 1'b1; load_val = 8'd0;
        tick();
        load = 1'b0;
        #1;
        vec_cnt++;
        if (wrap_cnt !== 2'd3) begin
            err_cnt++;
            $display("FAIL wrapcnt_load_keeps: got %0d want 3", wrap_cnt);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        vec_cnt++;
        if (wrap_cnt !== 2'd0) begin
            err_cnt++;
            $display("FAIL wrapcnt_clr: got %0d want 0", wrap_cnt);
        end
        $display("wrapcnt: after clr wrap_cnt=%0d", wrap_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_periodic_up();
        test_mod_write();
        test_down();
        test_oneshot();
        test_priority();
        test_m1();
        test_reset_midcount();
`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
        test_wrapcnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
